// File: rtl/cursor_ctrl.sv
// Board-cursor controller: held direction buttons move a cursor with press step and auto-repeat.
// Define CURSOR_WRAP_EN to wrap at board edges instead of clamping (blocked is then never asserted).
module cursor_ctrl #(
  parameter int unsigned COORD_W      = 3,
  parameter int unsigned BOARD_W      = 8,
  parameter int unsigned BOARD_H      = 8,
  parameter int unsigned HOME_X       = 4,
  parameter int unsigned HOME_Y       = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_en,
  input  logic               right,
  input  logic               left,
  input  logic               up,
  input  logic               down,
  input  logic               home,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               moved,
  output logic               blocked
);

  localparam int unsigned MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]   DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]   RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(BOARD_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(BOARD_H - 1);
  localparam logic [COORD_W-1:0] X_HOME     = COORD_W'(HOME_X);
  localparam logic [COORD_W-1:0] Y_HOME     = COORD_W'(HOME_Y);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} stateT;

  stateT              state, stateNext;
  logic [CNT_W-1:0]   count, countNext;
  logic [3:0]         dir, dirLat, dirLatNext;
  logic               dirActive;
  logic               doStep;
  logic               xInc, xDec, yInc, yDec;
  logic [COORD_W-1:0] stepX, stepY, xNext, yNext;
  logic               movedNext, blockedNext;

  // Opposing buttons cancel per axis; encoded as {x+, x-, y+, y-}
  assign xInc      = right & ~left;
  assign xDec      = left & ~right;
  assign yInc      = down & ~up;
  assign yDec      = up & ~down;
  assign dir       = {xInc, xDec, yInc, yDec};
  assign dirActive = |dir;

  // Candidate position for a step; each axis clamps or wraps on its own
  always_comb begin
    stepX = cur_x;
    stepY = cur_y;
    if (xInc) begin
`ifdef CURSOR_WRAP_EN
      stepX = (cur_x == X_MAX) ? '0 : cur_x + COORD_W'(1);
`else
      stepX = (cur_x == X_MAX) ? cur_x : cur_x + COORD_W'(1);
`endif
    end else if (xDec) begin
`ifdef CURSOR_WRAP_EN
      stepX = (cur_x == '0) ? X_MAX : cur_x - COORD_W'(1);
`else
      stepX = (cur_x == '0) ? cur_x : cur_x - COORD_W'(1);
`endif
    end
    if (yInc) begin
`ifdef CURSOR_WRAP_EN
      stepY = (cur_y == Y_MAX) ? '0 : cur_y + COORD_W'(1);
`else
      stepY = (cur_y == Y_MAX) ? cur_y : cur_y + COORD_W'(1);
`endif
    end else if (yDec) begin
`ifdef CURSOR_WRAP_EN
      stepY = (cur_y == '0) ? Y_MAX : cur_y - COORD_W'(1);
`else
      stepY = (cur_y == '0) ? cur_y : cur_y - COORD_W'(1);
`endif
    end
  end

  // Next-state, repeat timing, and position/pulse decode
  always_comb begin
    stateNext   = state;
    countNext   = count;
    dirLatNext  = dirLat;
    doStep      = 1'b0;
    xNext       = cur_x;
    yNext       = cur_y;
    movedNext   = 1'b0;
    blockedNext = 1'b0;

    if (tick_en) begin
      case (state)
        IDLE: begin
          if (dirActive) begin
            doStep     = 1'b1;
            dirLatNext = dir;
            countNext  = '0;
            stateNext  = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (!dirActive) begin
            stateNext = IDLE;
            countNext = '0;
          end else if (dir != dirLat) begin
            // A new direction is treated as a fresh press
            doStep     = 1'b1;
            dirLatNext = dir;
            countNext  = '0;
            stateNext  = DELAY;
          end else if (count == ((state == DELAY) ? DELAY_LAST : RATE_LAST)) begin
            doStep    = 1'b1;
            countNext = '0;
            stateNext = REPEAT;
          end else begin
            countNext = count + CNT_W'(1);
          end
        end
        LOCK: begin
          if (!dirActive) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end

    if (home) begin
      stateNext = LOCK;
      countNext = '0;
      xNext     = X_HOME;
      yNext     = Y_HOME;
      movedNext = (cur_x != X_HOME) || (cur_y != Y_HOME);
    end else if (doStep) begin
      xNext     = stepX;
      yNext     = stepY;
      movedNext = (stepX != cur_x) || (stepY != cur_y);
`ifndef CURSOR_WRAP_EN
      blockedNext = (stepX == cur_x) && (stepY == cur_y);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      dirLat  <= '0;
      cur_x   <= X_HOME;
      cur_y   <= Y_HOME;
      moved   <= 1'b0;
      blocked <= 1'b0;
    end else begin
      state   <= stateNext;
      count   <= countNext;
      dirLat  <= dirLatNext;
      cur_x   <= xNext;
      cur_y   <= yNext;
      moved   <= movedNext;
      blocked <= blockedNext;
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Self-checking bench for cursor_ctrl (REPEAT_DELAY=4, REPEAT_RATE=2); honours CURSOR_WRAP_EN.
module tb_cursor_ctrl;

  localparam int BW = 8;
  localparam int BH = 8;
  localparam int HX = 4;
  localparam int HY = 4;
  localparam int RD = 4;
  localparam int RR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tickEn = 1'b1;
  logic       btnRight = 1'b0, btnLeft = 1'b0, btnUp = 1'b0, btnDown = 1'b0;
  logic       btnHome = 1'b0;
  logic [2:0] curX, curY;
  logic       moved, blocked;

  int checks = 0;
  int errors = 0;

  cursor_ctrl #(
    .COORD_W(3), .BOARD_W(BW), .BOARD_H(BH), .HOME_X(HX), .HOME_Y(HY),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .tick_en(tickEn),
    .right(btnRight), .left(btnLeft), .up(btnUp), .down(btnDown), .home(btnHome),
    .cur_x(curX), .cur_y(curY), .moved(moved), .blocked(blocked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a press steps at once, then a held run of n ticks steps when n>=RD and (n-RD)%RR==0
  int mx = HX, my = HY;
  int mMoved = 0, mBlocked = 0;
  bit active = 0, locked = 0;
  int runN = 0, lastDx = 0, lastDy = 0;

  function automatic int moveAxis(input int pos, input int d, input int lim);
`ifdef CURSOR_WRAP_EN
    return (pos + d + lim) % lim;
`else
    if (pos + d < 0 || pos + d >= lim) return pos;
    return pos + d;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mx = HX; my = HY; mMoved = 0; mBlocked = 0;
      active = 0; locked = 0; runN = 0; lastDx = 0; lastDy = 0;
    end else begin
      int dx, dy, nx, ny;
      bit step;
      dx = (btnRight && !btnLeft) ? 1 : ((btnLeft && !btnRight) ? -1 : 0);
      dy = (btnDown && !btnUp) ? 1 : ((btnUp && !btnDown) ? -1 : 0);
      mMoved = 0; mBlocked = 0; step = 0;
      if (btnHome) begin
        mMoved = (mx != HX || my != HY) ? 1 : 0;
        mx = HX; my = HY; locked = 1; active = 0;
      end else if (tickEn) begin
        if (dx == 0 && dy == 0) begin
          active = 0; locked = 0;
        end else if (!locked) begin
          if (!active || dx != lastDx || dy != lastDy) begin
            active = 1; lastDx = dx; lastDy = dy; runN = 0; step = 1;
          end else begin
            runN++;
            step = (runN >= RD) && ((runN - RD) % RR == 0);
          end
        end
        if (step) begin
          nx = moveAxis(mx, dx, BW);
          ny = moveAxis(my, dy, BH);
          mMoved = (nx != mx || ny != my) ? 1 : 0;
`ifndef CURSOR_WRAP_EN
          mBlocked = (nx == mx && ny == my) ? 1 : 0;
`endif
          mx = nx; my = ny;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      check("cmp_x", int'(curX), mx);
      check("cmp_y", int'(curY), my);
      check("cmp_moved", int'(moved), mMoved);
      check("cmp_blocked", int'(blocked), mBlocked);
    end
  end

  task automatic lit(input string tag, input int ex, input int ey, input int em, input int eb);
    check({tag, "_x"}, int'(curX), ex);
    check({tag, "_y"}, int'(curY), ey);
    check({tag, "_moved"}, int'(moved), em);
    check({tag, "_blocked"}, int'(blocked), eb);
  endtask

  task automatic tick(input bit r, input bit l, input bit u, input bit d);
    btnRight = r; btnLeft = l; btnUp = u; btnDown = d;
    @(negedge clk);
  endtask

  task automatic doHome();
    btnRight = 0; btnLeft = 0; btnUp = 0; btnDown = 0; btnHome = 1;
    @(negedge clk);
    btnHome = 0;
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    lit("reset", 4, 4, 0, 0);

    // Single-tick press, one-cycle pulse, then IDLE accepts an immediate new press
    tick(1, 0, 0, 0); lit("pulse_step", 5, 4, 1, 0);
    tick(0, 0, 0, 0); lit("pulse_drop", 5, 4, 0, 0);
    tick(1, 0, 0, 0); lit("repress", 6, 4, 1, 0);
    tick(0, 0, 0, 0);
    doHome(); lit("home1", 4, 4, 1, 0);
    tick(0, 0, 0, 0);

    // Held right: steps on ticks 1, 5, 7, 9
    for (int i = 1; i <= 10; i++) begin
      tick(1, 0, 0, 0);
      if (i == 1) lit("hold_t1", 5, 4, 1, 0);
      if (i == 5) lit("hold_t5", 6, 4, 1, 0);
      if (i == 7) lit("hold_t7", 7, 4, 1, 0);
`ifdef CURSOR_WRAP_EN
      if (i == 9) lit("hold_t9", 0, 4, 1, 0);
`else
      if (i == 9) lit("hold_t9", 7, 4, 0, 1);
`endif
    end
    tick(0, 0, 0, 0);
    doHome(); lit("home2", 4, 4, 1, 0);
    tick(0, 0, 0, 0);

    // Diagonal and cancelling buttons
    tick(0, 1, 1, 0); lit("diag", 3, 3, 1, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 0); lit("cancel", 3, 3, 0, 0);
    end
    tick(0, 0, 0, 0);

    // Walk to the left edge, then partial clamp on a diagonal
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
    end
    lit("edge", 0, 3, 0, 0);
    tick(0, 1, 0, 1);
`ifdef CURSOR_WRAP_EN
    lit("partial", 7, 4, 1, 0);
`else
    lit("partial", 0, 4, 1, 0);
`endif
    tick(0, 0, 0, 0);

    // Home while down is held locks the cursor until release
    doHome(); lit("home3", 4, 4, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1); lit("down_t1", 4, 5, 1, 0);
    tick(0, 0, 0, 1);
    btnHome = 1; tick(0, 0, 0, 1); btnHome = 0;
    lit("home_held", 4, 4, 1, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1);
    lit("locked", 4, 4, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1); lit("unlock", 4, 5, 1, 0);
    tick(0, 0, 0, 0);

    // tick_en low freezes everything
    tickEn = 1'b0;
    for (int i = 0; i < 20; i++) tick(1, 0, 0, 0);
    lit("frozen", 4, 5, 0, 0);
    tickEn = 1'b1;
    for (int i = 1; i <= 5; i++) tick(1, 0, 0, 0);
    lit("rep_t5", 6, 5, 1, 0);

    // Asynchronous reset mid-REPEAT, away from any clock edge
    #2 reset = 1'b1;
    #1 lit("async_rst", 4, 4, 0, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    lit("post_rst", 5, 4, 1, 0);
    tick(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
